// File: rtl/result_drain_ctrl.sv
// Purpose: drains DEPTH words from result RAM B (addresses 0..DEPTH-1) onto a valid/ready stream, then pulses Done.
// Latency: first OutValid 2 cycles after Start is sampled, then one word per cycle; Done the cycle after the last transfer.
// Backpressure: reads stall while buffered + in-flight words would exceed 2; OutData holds while OutReady=0, nothing is dropped.
module result_drain_ctrl #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              Start,
    output logic              REB,
    output logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] DataB,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              Busy,
    output logic              Done
);

    localparam int               CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic             issue;      // a RAM B read is launched this cycle
    logic             xfer;       // a word is accepted downstream this cycle
    logic             inflight;   // read launched last cycle, DataB valid now
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] xfer_cnt;
    logic [1:0]       occ;        // words held in the buffer plus the in-flight read

    // Two-entry output buffer; its head drives the stream.
    logic [DATA_W-1:0] skid_mem [2];
    logic              skid_wr;
    logic              skid_rd;
    logic [1:0]        skid_cnt;

    assign xfer     = OutValid & OutReady;
    assign OutValid = (skid_cnt != 2'd0);
    assign OutData  = skid_mem[skid_rd];
    assign occ      = skid_cnt + {1'b0, inflight};
    assign REB      = issue;
    assign Busy     = (state != IDLE);
    assign Done     = (state == DONE);

    // State register.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and read issue. A full pipeline (occ=2) may still issue when a
    // word leaves this cycle, which keeps one word per cycle under OutReady=1.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                issue = (occ < 2'd2) || xfer;
                if (issue && (issue_cnt == LAST)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (xfer && (xfer_cnt == LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address, counters and in-flight tracking; a new drain restarts from address 0.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            AddrB     <= '0;
            issue_cnt <= '0;
            xfer_cnt  <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if ((state == IDLE) && Start) begin
                AddrB     <= '0;
                issue_cnt <= '0;
                xfer_cnt  <= '0;
            end else begin
                if (issue) begin
                    AddrB     <= AddrB + ADDR_W'(1);
                    issue_cnt <= issue_cnt + CNT_W'(1);
                end
                if (xfer) begin
                    xfer_cnt <= xfer_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Output buffer: returning read data is pushed, accepted words are popped, both may happen together.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
            skid_wr     <= 1'b0;
            skid_rd     <= 1'b0;
            skid_cnt    <= 2'd0;
        end else begin
            if (inflight) begin
                skid_mem[skid_wr] <= DataB;
                skid_wr           <= ~skid_wr;
            end
            if (xfer) begin
                skid_rd <= ~skid_rd;
            end
            skid_cnt <= skid_cnt + {1'b0, inflight} - {1'b0, xfer};
        end
    end

endmodule

// File: doc/result_drain_ctrl.md
Name: result_drain_ctrl

Overview:
- Read-side sequencer for result RAM B; the write-side controller fills RAM B during the compute phase.
- On Start, it reads DEPTH words from RAM B, addresses 0 to DEPTH-1 in order.
- It streams the words out on a valid/ready interface with full throughput and lossless backpressure.
- It pulses Done once the last word has been accepted downstream.

Parameters:
- ADDR_W, 2, RAM B address width.
- DATA_W, 8, RAM B data width.
- DEPTH, 4, number of words drained per Start (1..2^ADDR_W).

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin a drain; sampled in IDLE only.
- REB  out  1  RAM B read enable.
- AddrB  out  ADDR_W  RAM B read address.
- DataB  in  DATA_W  RAM B read data; valid exactly 1 cycle after a cycle with REB=1.
- OutData  out  DATA_W  streamed result word.
- OutValid  out  1  OutData valid.
- OutReady  in  1  downstream accept; transfer occurs when OutValid=1 and OutReady=1.
- Busy  out  1  high from the cycle after Start is accepted until Done.
- Done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE, REB=0, AddrB=0, OutValid=0, OutData=0, Busy=0, Done=0, skid buffer empty, in-flight flag=0, issue count=0, transfer count=0.
- States: IDLE, READ, FLUSH, DONE.
  - IDLE: Start=1 -> READ; AddrB=0, issue count=0, transfer count=0.
  - READ: issues reads. After issuing the DEPTH-th read -> FLUSH.
  - FLUSH: no reads issued. Once transfer count reaches DEPTH -> DONE.
  - DONE: Done=1 for exactly one cycle, then -> IDLE.
- Busy = (state != IDLE). Start is ignored outside IDLE.
- Buffering is a 2-entry FIFO; its head drives OutData/OutValid. Occupancy = entries held + in-flight read (0..2).
- Read issue condition: state=READ, and either occupancy<2, or occupancy=2 and a transfer happens this cycle.
- REB is combinational from the issue condition. AddrB is registered: it increments after each issue and holds otherwise.
- Returning DataB is written into the FIFO on the cycle after REB. A simultaneous push and pop is legal.
- Word order on OutData equals address order 0..DEPTH-1, with no loss or duplication under any OutReady pattern.
- Throughput: with OutReady held at 1, first OutValid appears 2 cycles after Start is sampled, then one word per cycle.
- Latency: Done is asserted the cycle after the final transfer.
- OutData is stable while OutValid=1 and OutReady=0.
- Counters: issue count and transfer count are ADDR_W+1 bits wide. AddrB does not wrap mid-drain; it wraps to 0 only when DEPTH=2^ADDR_W, after the last issue.
- Reset mid-operation: all state is cleared immediately, any in-flight data is discarded, and no Done is produced.
- Start is held high: one drain runs; a new drain begins on the cycle after DONE returns to IDLE.

Test Plan:
- Reset low, then high, Start pulse, OutReady=1, RAM B holds {0x11,0x22,0x33,0x44}:
  - REB high on 4 consecutive cycles, AddrB 0,1,2,3.
  - OutData 0x11..0x44 on 4 consecutive cycles.
  - Done pulses 1 cycle after the 0x44 transfer.
  - Busy falls the same cycle Done falls.
- Same data, OutReady=0 for 5 cycles after Start:
  - REB stops after 2 issues; OutData holds 0x11.
  - When OutReady=1, all 4 words arrive in order with no duplicates.
- OutReady toggling 1,0,1,0:
  - Exactly 4 transfers, order 0x11,0x22,0x33,0x44.
  - No transfer while OutReady=0.
  - Exactly one Done pulse.
- Start pulsed again while Busy=1: ignored. AddrB and the word sequence are unaffected; only one Done.
- Reset driven low after the second transfer:
  - Outputs go to reset values immediately.
  - No Done; the next Start drains from address 0 again.
- DEPTH=4, ADDR_W=2, Start held high for 20 cycles: back-to-back drains, each yielding 4 words and separated by the DONE and IDLE cycles.
